// File: rtl/mdio_slave_if.sv
// MDIO pad pins plus register-side access bus between an MDIO responder and its register file.
// Pure signal bundle; the slave modport is the responder view, the master modport is the host/bench view.
interface mdio_slave_if;
    logic        mdc_i;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_t;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wr_data;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [15:0] reg_rd_data;
    logic        busy;

    modport slave (
        input  mdc_i,
        input  mdio_i,
        input  reg_rd_data,
        output mdio_o,
        output mdio_t,
        output reg_addr,
        output reg_wr_data,
        output reg_wr_en,
        output reg_rd_en,
        output busy
    );

    modport master (
        output mdc_i,
        output mdio_i,
        output reg_rd_data,
        input  mdio_o,
        input  mdio_t,
        input  reg_addr,
        input  reg_wr_data,
        input  reg_wr_en,
        input  reg_rd_en,
        input  busy
    );
endinterface

// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder: frames in from MDC/MDIO pads, one-cycle register strobes out (MDIO_SLAVE_BCAST_WR_EN: accept PHYAD 0 writes).
// Latency: pad edges seen 3 clk late; wr strobe 1 clk after 16th data sample, rd strobe 1 clk after header, data latched 1 clk later.
// Backpressure: none; register side must accept strobes and return read data the cycle after reg_rd_en.
module mdio_slave (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  phy_addr,
    mdio_slave_if.slave bus
);

    typedef enum logic [2:0] {
        PREAMBLE,
        HEADER,
        WR_TA,
        WR_DATA,
        RD_TA,
        RD_DATA
    } state_t;

    localparam logic [5:0] PRE_FULL = 6'd32;
    localparam logic [1:0] OP_WR    = 2'b01;
    localparam logic [1:0] OP_RD    = 2'b10;

    logic        mdc_s1;
    logic        mdc_s2;
    logic        mdc_d;
    logic        mdio_s1;
    logic        mdio_s2;
    logic        mdc_rise;
    logic        mdc_fall;

    state_t      state;
    logic [5:0]  pre_cnt;
    logic [4:0]  bit_cnt;
    logic [14:0] shreg;
    logic [15:0] rd_shreg;
    logic        rd_en_d;

    logic        mdio_o_r;
    logic        mdio_t_r;
    logic [4:0]  reg_addr_r;
    logic [15:0] reg_wr_data_r;
    logic        wr_en_r;
    logic        rd_en_r;
    logic        busy_r;

    logic [12:0] hdr_word;
    logic        hdr_st;
    logic [1:0]  hdr_op;
    logic [4:0]  hdr_phy;
    logic [4:0]  hdr_reg;
    logic [15:0] wr_word;
    logic        wr_match;
    logic        rd_match;

    // Pads are asynchronous; MDIO idles high so its synchronizer resets to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_s1  <= 1'b0;
            mdc_s2  <= 1'b0;
            mdc_d   <= 1'b0;
            mdio_s1 <= 1'b1;
            mdio_s2 <= 1'b1;
        end else begin
            mdc_s1  <= bus.mdc_i;
            mdc_s2  <= mdc_s1;
            mdc_d   <= mdc_s2;
            mdio_s1 <= bus.mdio_i;
            mdio_s2 <= mdio_s1;
        end
    end

    assign mdc_rise = mdc_s2 & ~mdc_d;
    assign mdc_fall = ~mdc_s2 & mdc_d;

    // Header as it will look once the current (13th) bit is shifted in.
    assign hdr_word = {shreg[11:0], mdio_s2};
    assign hdr_st   = hdr_word[12];
    assign hdr_op   = hdr_word[11:10];
    assign hdr_phy  = hdr_word[9:5];
    assign hdr_reg  = hdr_word[4:0];
    assign wr_word  = {shreg, mdio_s2};

`ifdef MDIO_SLAVE_BCAST_WR_EN
    assign wr_match = (hdr_phy == phy_addr) || (hdr_phy == 5'd0);
`else
    assign wr_match = (hdr_phy == phy_addr);
`endif
    assign rd_match = (hdr_phy == phy_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= PREAMBLE;
            pre_cnt       <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            rd_shreg      <= '0;
            rd_en_d       <= 1'b0;
            mdio_o_r      <= 1'b1;
            mdio_t_r      <= 1'b1;
            reg_addr_r    <= '0;
            reg_wr_data_r <= '0;
            wr_en_r       <= 1'b0;
            rd_en_r       <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            wr_en_r <= 1'b0;
            rd_en_r <= 1'b0;
            rd_en_d <= rd_en_r;
            if (rd_en_d) begin
                rd_shreg <= bus.reg_rd_data;
            end

            case (state)
                PREAMBLE: begin
                    if (mdc_rise) begin
                        if (mdio_s2) begin
                            if (pre_cnt != PRE_FULL) begin
                                pre_cnt <= pre_cnt + 6'd1;
                            end
                        end else if (pre_cnt == PRE_FULL) begin
                            state   <= HEADER;
                            busy_r  <= 1'b1;
                            bit_cnt <= '0;
                            pre_cnt <= '0;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end
                end

                HEADER: begin
                    if (mdc_rise) begin
                        shreg <= {shreg[13:0], mdio_s2};
                        if (bit_cnt == 5'd12) begin
                            bit_cnt <= '0;
                            if (hdr_st && (hdr_op == OP_WR) && wr_match) begin
                                state      <= WR_TA;
                                reg_addr_r <= hdr_reg;
                            end else if (hdr_st && (hdr_op == OP_RD) && rd_match) begin
                                state      <= RD_TA;
                                reg_addr_r <= hdr_reg;
                                rd_en_r    <= 1'b1;
                            end else begin
                                state   <= PREAMBLE;
                                pre_cnt <= '0;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                WR_TA: begin
                    if (mdc_rise) begin
                        if (bit_cnt == 5'd1) begin
                            state   <= WR_DATA;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                WR_DATA: begin
                    if (mdc_rise) begin
                        shreg <= wr_word[14:0];
                        if (bit_cnt == 5'd15) begin
                            reg_wr_data_r <= wr_word;
                            wr_en_r       <= 1'b1;
                            state         <= PREAMBLE;
                            pre_cnt       <= '0;
                            bit_cnt       <= '0;
                            busy_r        <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                // First fall after the header leaves the line to the master's pull-up; the second drives TA low.
                RD_TA: begin
                    if (mdc_fall) begin
                        if (bit_cnt == 5'd0) begin
                            bit_cnt <= 5'd1;
                        end else begin
                            state    <= RD_DATA;
                            bit_cnt  <= '0;
                            mdio_t_r <= 1'b0;
                            mdio_o_r <= 1'b0;
                        end
                    end
                end

                RD_DATA: begin
                    if (mdc_fall) begin
                        if (bit_cnt == 5'd16) begin
                            state    <= PREAMBLE;
                            pre_cnt  <= '0;
                            bit_cnt  <= '0;
                            mdio_t_r <= 1'b1;
                            mdio_o_r <= 1'b1;
                            busy_r   <= 1'b0;
                        end else begin
                            mdio_o_r <= rd_shreg[15];
                            rd_shreg <= {rd_shreg[14:0], 1'b0};
                            bit_cnt  <= bit_cnt + 5'd1;
                        end
                    end
                end

                default: begin
                    state    <= PREAMBLE;
                    pre_cnt  <= '0;
                    bit_cnt  <= '0;
                    mdio_t_r <= 1'b1;
                    mdio_o_r <= 1'b1;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mdio_o      = mdio_o_r;
    assign bus.mdio_t      = mdio_t_r;
    assign bus.reg_addr    = reg_addr_r;
    assign bus.reg_wr_data = reg_wr_data_r;
    assign bus.reg_wr_en   = wr_en_r;
    assign bus.reg_rd_en   = rd_en_r;
    assign bus.busy        = busy_r;

endmodule
